// File: rtl/aib_link_pkg.sv
// aib_link_pkg: state encoding, default parameters and channel-range helper for the AIB link sequencer.
package aib_link_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RST_HOLD  = 3'd1,
        ADPT_WAIT = 3'd2,
        MAC_WAIT  = 3'd3,
        LINK_UP   = 3'd4,
        ERROR     = 3'd5
    } link_state_e;

    localparam int DefNumChannels   = 6;
    localparam int DefRstCycles     = 64;
    localparam int DefTimeoutCycles = 65536;
    localparam int DefMaxRetries    = 3;
    // MAC status is only trusted once our own o_ns_mac_rdy can have crossed the far-side synchronizer
    localparam int MacSettleCycles  = 3;

    function automatic logic chan_in_range(input int idx, input logic [2:0] first, input logic [2:0] last);
        return (idx >= int'(first)) && (idx <= int'(last));
    endfunction

endpackage

// File: rtl/aib_sync2.sv
// aib_sync2: two-flop synchronizer for one asynchronous far-side status bit.
module aib_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/aib_link_ctrl.sv
// aib_link_ctrl: AIB link bring-up sequencer with timeout/link-loss retry and bounded error latch.
module aib_link_ctrl
    import aib_link_pkg::*;
#(
    parameter int NumChannels   = DefNumChannels,
    parameter int RstCycles     = DefRstCycles,
    parameter int TimeoutCycles = DefTimeoutCycles,
    parameter int MaxRetries    = DefMaxRetries
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_start,
    input  logic [2:0]                        c_first_chn_id,
    input  logic [2:0]                        c_last_chn_id,
    input  logic [NumChannels-1:0]            i_fs_adapter_rstn,
    input  logic [NumChannels-1:0]            i_fs_mac_rdy,
    input  logic [NumChannels-1:0]            i_rx_aligned,
    output logic [NumChannels-1:0]            o_ns_adapter_rstn,
    output logic [NumChannels-1:0]            o_ns_mac_rdy,
    output logic                              o_link_up,
    output logic                              o_error,
    output logic [2:0]                        o_state,
    output logic [$clog2(MaxRetries+1)-1:0]   o_retry_cnt
);
    localparam int HW = (RstCycles > 1) ? $clog2(RstCycles) : 1;
    localparam int TW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam int RW = $clog2(MaxRetries + 1);

    link_state_e            state, next_state;
    logic [NumChannels-1:0] fs_adpt, fs_mac, rx_al, mask, cfg_mask;
    logic [HW-1:0]          hold_cnt;
    logic [TW-1:0]          timer;
    logic [RW-1:0]          retry_cnt;
    logic                   adpt_ok, mac_ok, range_bad, hold_done, timed_out, settled, retry;

    for (genvar g = 0; g < NumChannels; g++) begin : g_sync
        aib_sync2 u_adpt (.clk(i_clk), .rst_n(i_rst_n), .d(i_fs_adapter_rstn[g]), .q(fs_adpt[g]));
        aib_sync2 u_mac  (.clk(i_clk), .rst_n(i_rst_n), .d(i_fs_mac_rdy[g]),      .q(fs_mac[g]));
        aib_sync2 u_rx   (.clk(i_clk), .rst_n(i_rst_n), .d(i_rx_aligned[g]),      .q(rx_al[g]));
    end

    always_comb begin
        cfg_mask = '0;
        for (int i = 0; i < NumChannels; i++)
            cfg_mask[i] = chan_in_range(i, c_first_chn_id, c_last_chn_id);
    end

    // Unmasked channels count as ready so they never gate a decision
    assign adpt_ok   = &(fs_adpt | ~mask);
    assign mac_ok    = &((fs_mac & rx_al) | ~mask);
    assign range_bad = (c_first_chn_id > c_last_chn_id) || (32'(c_last_chn_id) >= NumChannels);
    assign hold_done = 32'(hold_cnt) == RstCycles - 1;
    assign timed_out = 32'(timer) == TimeoutCycles - 1;
    assign settled   = 32'(timer) >= MacSettleCycles;

    always_comb begin
        next_state = state;
        retry      = 1'b0;
        case (state)
            IDLE:      next_state = !i_start ? IDLE : range_bad ? ERROR : RST_HOLD;
            RST_HOLD:  next_state = hold_done ? ADPT_WAIT : RST_HOLD;
            ADPT_WAIT: begin
                next_state = adpt_ok ? MAC_WAIT : ADPT_WAIT;
                retry      = !adpt_ok && timed_out;
            end
            MAC_WAIT:  begin
                next_state = (mac_ok && settled) ? LINK_UP : MAC_WAIT;
                retry      = !(mac_ok && settled) && timed_out;
            end
            LINK_UP:   retry = !mac_ok;
            ERROR:     next_state = i_start ? ERROR : IDLE;
            default:   next_state = IDLE;
        endcase
        if (retry)
            next_state = (32'(retry_cnt) == MaxRetries) ? ERROR : RST_HOLD;
        if (!i_start && state != ERROR)
            next_state = IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state             <= IDLE;
            mask              <= '0;
            hold_cnt          <= '0;
            timer             <= '0;
            retry_cnt         <= '0;
            o_ns_adapter_rstn <= '0;
            o_ns_mac_rdy      <= '0;
            o_link_up         <= 1'b0;
            o_error           <= 1'b0;
        end else begin
            state     <= next_state;
            hold_cnt  <= (state == RST_HOLD && next_state == RST_HOLD) ? hold_cnt + 1'b1 : '0;
            timer     <= (state inside {ADPT_WAIT, MAC_WAIT} && next_state == state) ? timer + 1'b1 : '0;
            retry_cnt <= (next_state == IDLE) ? '0 : (retry && next_state == RST_HOLD) ? retry_cnt + 1'b1 : retry_cnt;
            if (state == IDLE && next_state == RST_HOLD)
                mask <= cfg_mask;
            o_ns_adapter_rstn <= (state inside {ADPT_WAIT, MAC_WAIT, LINK_UP}) ? mask : '0;
            o_ns_mac_rdy      <= (state inside {MAC_WAIT, LINK_UP}) ? mask : '0;
            o_link_up         <= state == LINK_UP;
            o_error           <= state == ERROR;
        end
    end

    assign o_state     = state;
    assign o_retry_cnt = retry_cnt;

endmodule
